// File: rtl/mapper_pkg.sv
// Shared encodings for the NABU mapper I/O replay path.
package mapper_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/io_replay_timer.sv
// Automatic-wait counter plus optional external-wait timeout (IO_REPLAY_TIMEOUT_EN).
module io_replay_timer #(
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  input  logic wait_n,
  output logic auto_done,
  output logic expired
);

  logic [2:0] auto_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_cnt <= '0;
    end else if (load) begin
      auto_cnt <= 3'(WAIT_STATES - 1);
    end else if (run && auto_cnt != '0) begin
      auto_cnt <= auto_cnt - 3'd1;
    end
  end

  // Zero during the last automatic TW and every TW after it.
  assign auto_done = (auto_cnt == '0);

`ifdef IO_REPLAY_TIMEOUT_EN
  logic [7:0] ext_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_cnt <= '0;
    end else if (load) begin
      ext_cnt <= '0;
    end else if (run && auto_done && !wait_n) begin
      ext_cnt <= ext_cnt + 8'd1;
    end
  end

  // The first low sample ends the automatic wait; the limit counts the extra TW cycles after it.
  assign expired = run && auto_done && !wait_n && (ext_cnt == 8'(TIMEOUT_CYCLES));
`else
  logic unused_cfg;
  assign unused_cfg = wait_n & (TIMEOUT_CYCLES > 0);
  assign expired    = 1'b0;
`endif

endmodule

// File: rtl/io_replay.sv
// Replays a trapped Z80 I/O access onto the system bus (T1, T2, TW.., T3).
// Optional timeout on sys_wait_n: define IO_REPLAY_TIMEOUT_EN.
module io_replay
  import mapper_pkg::*;
#(
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       cmd_dir,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  output logic [7:0] sys_addr,
  output logic [7:0] sys_data_out,
  output logic       sys_data_oe,
  input  logic [7:0] sys_data_in,
  output logic       sys_iorq_n,
  output logic       sys_rd_n,
  output logic       sys_wr_n,
  input  logic       sys_wait_n
);

  state_t state, next_state;
  logic   dir;
  logic   dir_next;
  logic   accept;
  logic   leave_tw;
  logic   strobe_next;
  logic   oe_next;
  logic   auto_done;
  logic   expired;

  io_replay_timer #(
    .WAIT_STATES   (WAIT_STATES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state == T2),
    .run      (state == TW),
    .wait_n   (sys_wait_n),
    .auto_done(auto_done),
    .expired  (expired)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_wr) next_state = T1;
      T1:      next_state = T2;
      T2:      next_state = TW;
      TW:      if (expired || (auto_done && sys_wait_n)) next_state = T3;
      T3:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state cycle.
  always_comb begin
    accept      = (state == IDLE) && cmd_wr;
    leave_tw    = (state == TW) && (next_state == T3);
    dir_next    = accept ? cmd_dir : dir;
    strobe_next = (next_state == T2) || (next_state == TW);
    oe_next     = (dir_next == DIR_OUT) &&
                  ((next_state == T1) || (next_state == T2) ||
                   (next_state == TW) || (next_state == T3));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dir          <= DIR_OUT;
      busy         <= 1'b0;
      done         <= 1'b0;
      rdata        <= '0;
      sys_addr     <= '0;
      sys_data_out <= '0;
      sys_data_oe  <= 1'b0;
      sys_iorq_n   <= 1'b1;
      sys_rd_n     <= 1'b1;
      sys_wr_n     <= 1'b1;
    end else begin
      state       <= next_state;
      busy        <= (next_state != IDLE);
      done        <= (next_state == DONE);
      sys_data_oe <= oe_next;
      sys_iorq_n  <= !strobe_next;
      sys_rd_n    <= !(strobe_next && dir_next == DIR_IN);
      sys_wr_n    <= !(strobe_next && dir_next == DIR_OUT);
      if (accept) begin
        dir          <= cmd_dir;
        sys_addr     <= cmd_addr;
        sys_data_out <= cmd_data;
      end
      if (leave_tw && dir == DIR_IN) begin
        rdata <= expired ? TIMEOUT_RDATA : sys_data_in;
      end
    end
  end

`ifdef IO_REPLAY_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (expired) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_io_replay.sv
// Directed bench for io_replay; timeout vectors run when IO_REPLAY_TIMEOUT_EN is defined.
module tb_io_replay;
  import mapper_pkg::*;

`ifdef IO_REPLAY_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 8;
`else
  localparam int unsigned TO_CYCLES = 255;
`endif
  localparam int WIN = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_wr = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_dir = 1'b0;
  logic       busy, done, err, sys_data_oe;
  logic       sys_iorq_n, sys_rd_n, sys_wr_n;
  logic [7:0] rdata, sys_addr, sys_data_out;
  logic [7:0] sys_data_in = '0;
  logic       sys_wait_n = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  int iorq_low, rd_low, wr_low, both_low, done_cnt, done_cyc, oe_cnt, oe_first;
  logic [7:0] dout_seen;
  logic       err_k1;

  io_replay #(
    .WAIT_STATES   (1),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_dir     (cmd_dir),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .sys_addr    (sys_addr),
    .sys_data_out(sys_data_out),
    .sys_data_oe (sys_data_oe),
    .sys_data_in (sys_data_in),
    .sys_iorq_n  (sys_iorq_n),
    .sys_rd_n    (sys_rd_n),
    .sys_wr_n    (sys_wr_n),
    .sys_wait_n  (sys_wait_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Cycle k is the k-th cycle after the edge that samples cmd_wr.
  task automatic run_io(input logic [7:0] addr, input logic [7:0] data, input logic dir,
                        input logic [7:0] base, input logic [7:0] inc,
                        input int wlo, input int whi,
                        input int pulse_k, input logic [7:0] pulse_addr);
    @(negedge clk);
    cmd_addr    = addr;
    cmd_data    = data;
    cmd_dir     = dir;
    cmd_wr      = 1'b1;
    sys_wait_n  = 1'b1;
    sys_data_in = base;
    @(posedge clk);
    #1;
    cmd_wr = 1'b0;
    iorq_low = 0; rd_low = 0; wr_low = 0; both_low = 0;
    done_cnt = 0; done_cyc = 0; oe_cnt = 0; oe_first = 0;
    dout_seen = '0; err_k1 = 1'b0;
    for (int k = 1; k <= WIN; k++) begin
      sys_wait_n  = !(k >= wlo && k <= whi);
      sys_data_in = base + 8'(k) * inc;
      if (k == pulse_k) begin
        cmd_wr   = 1'b1;
        cmd_addr = pulse_addr;
      end else begin
        cmd_wr = 1'b0;
      end
      @(negedge clk);
      if (!sys_iorq_n) iorq_low++;
      if (!sys_rd_n) rd_low++;
      if (!sys_wr_n) wr_low++;
      if (!sys_rd_n && !sys_wr_n) both_low++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (sys_data_oe) begin
        oe_cnt++;
        if (oe_first == 0) begin
          oe_first  = k;
          dout_seen = sys_data_out;
        end
      end
      if (k == 1) err_k1 = err;
      @(posedge clk);
      #1;
    end
    cmd_wr     = 1'b0;
    sys_wait_n = 1'b1;
  endtask

  initial begin
    int done_after_rst;
    #23;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_err", err, 0);
    check("rst_addr", sys_addr, 8'h00);
    check("rst_dout", sys_data_out, 8'h00);
    check("rst_oe", sys_data_oe, 0);
    check("rst_strobes", {sys_iorq_n, sys_rd_n, sys_wr_n}, 3'b111);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_io(8'h40, 8'h00, DIR_IN, 8'hA5, 8'h00, 0, 0, 0, 8'h00);
    check("rd_done_cyc", done_cyc, 5);
    check("rd_done_cnt", done_cnt, 1);
    check("rd_iorq_low", iorq_low, 2);
    check("rd_rd_low", rd_low, 2);
    check("rd_wr_low", wr_low, 0);
    check("rd_oe_cnt", oe_cnt, 0);
    check("rd_rdata", rdata, 8'hA5);
    check("rd_addr", sys_addr, 8'h40);

    run_io(8'h41, 8'h3C, DIR_OUT, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    check("wr_done_cyc", done_cyc, 5);
    check("wr_iorq_low", iorq_low, 2);
    check("wr_wr_low", wr_low, 2);
    check("wr_rd_low", rd_low, 0);
    check("wr_oe_first", oe_first, 1);
    check("wr_oe_cnt", oe_cnt, 4);
    check("wr_dout", dout_seen, 8'h3C);
    check("wr_rdata_hold", rdata, 8'hA5);
    check("wr_addr", sys_addr, 8'h41);

    // Wait low on the four samples from the end of the automatic TW; data ramps each cycle.
    run_io(8'h42, 8'h00, DIR_IN, 8'h10, 8'h01, 3, 6, 0, 8'h00);
    check("ext_done_cyc", done_cyc, 9);
    check("ext_iorq_low", iorq_low, 6);
    check("ext_rdata", rdata, 8'h17);
    check("ext_both_low", both_low, 0);

    run_io(8'h50, 8'h00, DIR_IN, 8'h66, 8'h00, 0, 0, 2, 8'h77);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_iorq_low", iorq_low, 2);
    check("ign_addr", sys_addr, 8'h50);
    check("ign_busy", busy, 0);

    @(negedge clk);
    cmd_addr = 8'h60; cmd_dir = DIR_IN; cmd_wr = 1'b1; sys_data_in = 8'h99;
    @(posedge clk);
    #1 cmd_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rd_low_pre", sys_rd_n, 0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_iorq", sys_iorq_n, 1);
    check("mid_rd", sys_rd_n, 1);
    check("mid_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    done_after_rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_after_rst++;
    end
    check("mid_no_done", done_after_rst, 0);
    check("mid_rdata", rdata, 8'h00);

`ifdef IO_REPLAY_TIMEOUT_EN
    run_io(8'h70, 8'h00, DIR_IN, 8'h33, 8'h00, 1, 99, 0, 8'h00);
    check("to_done_cyc", done_cyc, 13);
    check("to_done_cnt", done_cnt, 1);
    check("to_err", err, 1);
    check("to_rdata", rdata, TIMEOUT_RDATA);
    run_io(8'h71, 8'h00, DIR_IN, 8'h44, 8'h00, 0, 0, 0, 8'h00);
    check("to_err_clear", err_k1, 0);
    check("to_next_rdata", rdata, 8'h44);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
